cnt_sched: RTL and testbench

- Round-robin scheduler that shares one W-bit up-counter (sync clear, enable, registered count output) among NREQ requesters.
- Each requester asks for a run of cs_len counts. The block grants one requester at a time, clears the counter, and enables it until it reaches the requested length.
- It then pulses done to that requester and moves to the next.
- It sits between requester logic and the shared counter instance, and is the only driver of the counter's reset and enable.

---
 rtl/cnt_sched_pkg.sv | 15 +
 rtl/cnt_sched_defs.vh | 9 +
 rtl/cs_rr_pick.sv | 31 +++
 rtl/cnt_sched.sv | 117 +++++++++++
 tb/tb_cnt_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - shared state type and helpers for the counter scheduler
package cnt_sched_pkg;
`include "cnt_sched_defs.vh"

   typedef enum logic [CS_STATE_W-1:0] {
      ST_IDLE  = CS_ST_IDLE,
      ST_CLEAR = CS_ST_CLEAR,
      ST_COUNT = CS_ST_COUNT,
      ST_DONE  = CS_ST_DONE
   } cs_state_t;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/cnt_sched_defs.vh
// rtl/cnt_sched_defs.vh - scheduler state encodings and state width
`ifndef CNT_SCHED_DEFS_VH
`define CNT_SCHED_DEFS_VH
localparam int                    CS_STATE_W  = 2;
localparam logic [CS_STATE_W-1:0] CS_ST_IDLE  = 2'd0;
localparam logic [CS_STATE_W-1:0] CS_ST_CLEAR = 2'd1;
localparam logic [CS_STATE_W-1:0] CS_ST_COUNT = 2'd2;
localparam logic [CS_STATE_W-1:0] CS_ST_DONE  = 2'd3;
`endif

// File: rtl/cs_rr_pick.sv
// rtl/cs_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module cs_rr_pick
   import cnt_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = 2
)(
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx
);
   logic w_found;

   // Outer loop walks distance from ptr; constant inner index keeps selects static.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] &&
                ((int'(ptr) + k == i) || (int'(ptr) + k == i + NREQ))) begin
               w_found = 1'b1;
               gnt[i]  = 1'b1;
               idx     = PW'(i);
            end
         end
      end
   end
endmodule

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - round-robin scheduler sharing one up-counter among NREQ requesters
module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int CW   = 4
)(
   input  logic               cs_clk,
   input  logic               cs_rst,
   input  logic [NREQ-1:0]    cs_req,
   input  logic [NREQ*CW-1:0] cs_len,
   output logic [NREQ-1:0]    cs_gnt,
   output logic [NREQ-1:0]    cs_done,
   output logic               cs_busy,
   output logic               cs_cnt_rst,
   output logic               cs_cnt_en,
   input  logic [CW-1:0]      cs_cnt_val
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   cs_state_t       r_state, w_next;
   logic [PW-1:0]   r_ptr, r_idx, w_pick_idx, w_ptr_next;
   logic [NREQ-1:0] r_gnt, r_done, w_pick_gnt;
   logic [CW-1:0]   r_len, w_pick_len;
   logic            w_any, w_held, w_at_len;

   cs_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req (cs_req),
      .ptr (r_ptr),
      .gnt (w_pick_gnt),
      .idx (w_pick_idx)
   );

   // r_gnt is one-hot on the latched index while a run is live, so it doubles as the selector.
   assign w_any      = |cs_req;
   assign w_held     = |(cs_req & r_gnt);
   assign w_at_len   = (cs_cnt_val == r_len);
   assign w_ptr_next = PW'(wrap_inc(int'(r_idx), NREQ));
   assign cs_gnt     = r_gnt;
   assign cs_done    = r_done;

   always_comb begin
      w_pick_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick_gnt[i]) w_pick_len = cs_len[i*CW +: CW];
      end
   end

   always_ff @(posedge cs_clk or negedge cs_rst) begin
      if (!cs_rst) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_any) w_next = ST_CLEAR;
         ST_CLEAR: w_next = w_held ? ST_COUNT : ST_IDLE;
         ST_COUNT: begin
            if (!w_held)       w_next = ST_IDLE;
            else if (w_at_len) w_next = ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_busy    = 1'b0;
      cs_cnt_rst = 1'b0;
      cs_cnt_en  = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            cs_busy    = 1'b1;
            cs_cnt_rst = 1'b1;
         end
         ST_COUNT: begin
            cs_busy   = 1'b1;
            cs_cnt_en = w_held && !w_at_len;
         end
         ST_DONE:  cs_busy = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge cs_clk or negedge cs_rst) begin
      if (!cs_rst) begin
         r_gnt  <= '0;
         r_done <= '0;
         r_ptr  <= '0;
         r_idx  <= '0;
         r_len  <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt <= w_pick_gnt;
                  r_idx <= w_pick_idx;
                  r_len <= w_pick_len;
               end
            end
            ST_CLEAR, ST_COUNT: begin
               if (!w_held) begin
                  r_gnt <= '0;
                  r_ptr <= w_ptr_next;
               end else if (r_state == ST_COUNT && w_at_len) begin
                  r_gnt  <= '0;
                  r_done <= r_gnt;
               end
            end
            ST_DONE: r_ptr <= w_ptr_next;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cnt_sched.sv
// tb/tb_cnt_sched.sv - self-checking bench for cnt_sched with a behavioural scheduling model
module tb_cnt_sched;
   localparam int NREQ = 4;
   localparam int CW   = 4;

   logic               cs_clk = 1'b0;
   logic               cs_rst = 1'b0;
   logic [NREQ-1:0]    cs_req = '0;
   logic [NREQ*CW-1:0] cs_len = '0;
   logic [NREQ-1:0]    cs_gnt, cs_done;
   logic               cs_busy, cs_cnt_rst, cs_cnt_en;
   logic [CW-1:0]      cs_cnt_val = '0;

   int n_vec = 0;
   int n_err = 0;
   int m_ptr = 0;

   cnt_sched #(.NREQ(NREQ), .CW(CW)) dut (
      .cs_clk     (cs_clk),
      .cs_rst     (cs_rst),
      .cs_req     (cs_req),
      .cs_len     (cs_len),
      .cs_gnt     (cs_gnt),
      .cs_done    (cs_done),
      .cs_busy    (cs_busy),
      .cs_cnt_rst (cs_cnt_rst),
      .cs_cnt_en  (cs_cnt_en),
      .cs_cnt_val (cs_cnt_val)
   );

   always #5 cs_clk = ~cs_clk;

   // The shared counter the scheduler drives.
   always @(posedge cs_clk) begin
      if (cs_cnt_rst)     cs_cnt_val <= '0;
      else if (cs_cnt_en) cs_cnt_val <= cs_cnt_val + 1'b1;
   end

   always @(negedge cs_clk) begin
      n_vec++;
      assert ($countones(cs_gnt) <= 1) else begin
         n_err++;
         $error("FAIL gnt_multi_hot: got %b required at most one bit", cs_gnt);
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cs_clk);
      #1;
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++)
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic set_len(input int i, input int v);
      cs_len[i*CW +: CW] = v[CW-1:0];
   endtask

   // Follow one full run from acceptance to the done pulse.
   task automatic observe_run(input int exp_idx, input int exp_len, input int new_len);
      int  t, en_cnt, rst_cnt, gnt_cyc;
      bit  seen_done, gnt_bad;
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[exp_idx] = 1'b1;
      t = 0;
      while (cs_gnt == '0 && t < 6) begin
         tick();
         t++;
      end
      check("grant", 32'(cs_gnt), 32'(oh));
      if (new_len >= 0) set_len(exp_idx, new_len);
      en_cnt = 0; rst_cnt = 0; gnt_cyc = 0; seen_done = 0; gnt_bad = 0;
      for (int c = 0; c < exp_len + 8 && !seen_done; c++) begin
         if (cs_done != '0) seen_done = 1;
         else begin
            gnt_cyc++;
            en_cnt  += int'(cs_cnt_en);
            rst_cnt += int'(cs_cnt_rst);
            if (cs_gnt !== oh || cs_busy !== 1'b1) gnt_bad = 1;
            if (c == 1) check("first_count_val", 32'(cs_cnt_val), 32'd0);
            tick();
         end
      end
      check("done_seen", 32'(seen_done), 32'd1);
      check("done_onehot", 32'(cs_done), 32'(oh));
      check("gnt_cycles", 32'(gnt_cyc), 32'(exp_len + 2));
      check("en_cycles", 32'(en_cnt), 32'(exp_len));
      check("clear_cycles", 32'(rst_cnt), 32'd1);
      check("val_at_done", 32'(cs_cnt_val), 32'(exp_len));
      check("gnt_at_done", 32'(cs_gnt), 32'd0);
      check("gnt_stable", 32'(gnt_bad), 32'd0);
      m_ptr = (exp_idx + 1) % NREQ;
   endtask

   initial begin
      int idx, t, dn;
      logic [NREQ-1:0] mask;
      int lens[NREQ];

      #2;
      check("rst_gnt", 32'(cs_gnt), 32'd0);
      check("rst_done", 32'(cs_done), 32'd0);
      check("rst_busy", 32'(cs_busy), 32'd0);
      check("rst_cnt_rst", 32'(cs_cnt_rst), 32'd0);
      check("rst_cnt_en", 32'(cs_cnt_en), 32'd0);
      tick();
      cs_rst = 1'b1;
      tick();
      check("idle_busy", 32'(cs_busy), 32'd0);
      m_ptr = 0;

      // Single requester, length 5
      set_len(1, 5);
      cs_req = 4'b0010;
      observe_run(model_pick(cs_req, m_ptr), 5, -1);
      cs_req = '0;

      // Length 0
      set_len(2, 0);
      cs_req = 4'b0100;
      observe_run(model_pick(cs_req, m_ptr), 0, -1);
      cs_req = '0;

      // Abort after 4 counts
      set_len(0, 10);
      cs_req = 4'b0001;
      t = 0;
      while (cs_gnt == '0 && t < 6) begin tick(); t++; end
      check("abort_grant", 32'(cs_gnt), 32'd1);
      t = 0;
      while (cs_cnt_val != 4'd4 && t < 20) begin tick(); t++; end
      check("abort_val_reached", 32'(cs_cnt_val), 32'd4);
      cs_req = '0;
      #1;
      check("abort_en_drop", 32'(cs_cnt_en), 32'd0);
      tick();
      check("abort_gnt", 32'(cs_gnt), 32'd0);
      check("abort_busy", 32'(cs_busy), 32'd0);
      dn = 0;
      for (int c = 0; c < 4; c++) begin
         dn += int'(cs_done != '0);
         tick();
      end
      check("abort_no_done", 32'(dn), 32'd0);
      check("abort_val_hold", 32'(cs_cnt_val), 32'd4);
      m_ptr = 1;

      // Pointer moved past the aborted requester
      for (int i = 0; i < NREQ; i++) set_len(i, 0);
      cs_req = 4'b1111;
      observe_run(model_pick(cs_req, m_ptr), 0, -1);
      cs_req = '0;
      tick();

      // Fresh reset, then all requesting: rotation 0,1,2,3,0
      cs_rst = 1'b0;
      #1;
      cs_rst = 1'b1;
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) set_len(i, 2);
      cs_req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         idx = model_pick(cs_req, m_ptr);
         check("rotation_model", 32'(idx), 32'(r % NREQ));
         observe_run(idx, 2, -1);
      end
      cs_req = '0;
      tick();

      // Reset mid-COUNT
      set_len(3, 7);
      cs_req = 4'b1000;
      t = 0;
      while (cs_cnt_val != 4'd3 && t < 20) begin tick(); t++; end
      check("midrst_val", 32'(cs_cnt_val), 32'd3);
      cs_rst = 1'b0;
      #1;
      check("midrst_gnt", 32'(cs_gnt), 32'd0);
      check("midrst_busy", 32'(cs_busy), 32'd0);
      check("midrst_en", 32'(cs_cnt_en), 32'd0);
      tick();
      tick();
      cs_rst = 1'b1;
      m_ptr = 0;
      observe_run(model_pick(cs_req, m_ptr), 7, -1);
      cs_req = '0;

      // Length changed during a run is ignored
      set_len(0, 3);
      cs_req = 4'b0001;
      observe_run(model_pick(cs_req, m_ptr), 3, 9);
      cs_req = '0;

      // Randomized runs
      for (int r = 0; r < 16; r++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            lens[i] = int'($urandom_range(0, (1 << CW) - 1));
            set_len(i, lens[i]);
         end
         cs_req = mask;
         idx = model_pick(mask, m_ptr);
         observe_run(idx, lens[idx], -1);
         cs_req = '0;
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
